// File: rtl/mdp_fp_pkg.sv
// Shared definitions for the MDP front-end fixed-to-half-precision encoders.
package mdp_fp_pkg;
  localparam int FP_W        = 16;
  localparam int MANT_W      = 10;
  localparam int FRAC_W      = MANT_W + 1;  // mantissa plus guard bit
  localparam int FP_EXP_BIAS = 15;

  localparam logic [FP_W-1:0] FP_QNAN = 16'h7E00;
  localparam logic [6:0]      DIVISOR = 7'd100;

  // One-hot controller states
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_LOAD = 6'b000010,
    S_NORM = 6'b000100,
    S_DIV  = 6'b001000,
    S_PACK = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  // Out-of-range BCD digits saturate to 9
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/fp_frac_divider.sv
// Restoring divider: fractional quotient of dividend/DIVISOR where the
// dividend lies in [DIVISOR, 2*DIVISOR). The integer quotient bit is always 1
// and is dropped; FRAC_W fraction bits are produced, one per step.
module fp_frac_divider
  import mdp_fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [7:0]        dividend,
  output logic [FRAC_W-1:0] frac,
  output logic              sticky,
  output logic              last_step,
  output logic              done
);
  logic [6:0] rem;
  logic [3:0] cnt;
  logic [7:0] rem2;
  logic [7:0] rem_sub;
  logic       ge;
  logic [7:0] start_rem;

  assign rem2      = {rem, 1'b0};
  assign ge        = rem2 >= {1'b0, DIVISOR};
  assign rem_sub   = rem2 - {1'b0, DIVISOR};
  assign start_rem = dividend - {1'b0, DIVISOR};

  assign sticky    = rem != 7'd0;
  assign done      = cnt == 4'(FRAC_W);
  assign last_step = step && (cnt == 4'(FRAC_W - 1));

  // One quotient bit per step; start strips the implicit integer bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      cnt  <= '0;
      frac <= '0;
    end else if (start) begin
      rem  <= start_rem[6:0];
      cnt  <= '0;
      frac <= '0;
    end else if (step && !done) begin
      frac <= {frac[FRAC_W-2:0], ge};
      rem  <= ge ? rem_sub[6:0] : rem2[6:0];
      cnt  <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/encode_fp.sv
// Encodes 0.D1D2 (two BCD digits) into an IEEE-754 half-precision word.
// Flow: LOAD builds N=10*D1+D2, NORM shifts N into [100,200) counting k,
// DIV divides by 100 for 10 mantissa bits + guard, PACK rounds to nearest even.
// Optional macro BCD_CHECK_EN: invalid digits flag Err and return qNaN;
// without it invalid digits clamp to 9 and Err is tied low.
module encode_fp
  import mdp_fp_pkg::*;
(
  input  logic            clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Ack,
  input  logic [3:0]      Digit_1,
  input  logic [3:0]      Digit_2,
  output logic [FP_W-1:0] Fp_out,
  output logic            Done,
  output logic            Busy,
  output logic            Err
);
  state_t            state;
  logic [3:0]        d1, d2;
  logic [6:0]        nshift;
  logic [2:0]        k;
  logic              zero;
  logic [6:0]        n_load;
  logic [7:0]        nx2;
  logic              div_start, div_step;
  logic [FRAC_W-1:0] frac;
  logic              sticky, last_step, div_done;
  logic              round_up;
  logic [MANT_W:0]   mant_r;
  logic [4:0]        exp_r;
  logic [FP_W-1:0]   pack_word;

`ifdef BCD_CHECK_EN
  logic err_q;
  logic bad_digit;
  assign bad_digit = (d1 > 4'd9) || (d2 > 4'd9);
  assign Err       = err_q;
`else
  assign Err = 1'b0;
`endif

  assign n_load    = 7'(clamp_bcd(d1)) * 7'd10 + 7'(clamp_bcd(d2));
  assign nx2       = {nshift, 1'b0};
  // Final normalising shift hands the value straight to the divider
  assign div_start = (state == S_NORM) && (nx2 >= {1'b0, DIVISOR});
  assign div_step  = state == S_DIV;

  fp_frac_divider u_div (
    .clk       (clk),
    .rst_n     (Reset_n),
    .start     (div_start),
    .step      (div_step),
    .dividend  (nx2),
    .frac      (frac),
    .sticky    (sticky),
    .last_step (last_step),
    .done      (div_done)
  );

  // Round-to-nearest-even and exponent assembly; mantissa carry bumps exp
  always_comb begin
    round_up = frac[0] & (sticky | frac[1]);
    mant_r   = {1'b0, frac[FRAC_W-1:1]} + {{MANT_W{1'b0}}, round_up};
    exp_r    = 5'(FP_EXP_BIAS) - {2'b00, k};
    if (mant_r[MANT_W]) begin
      exp_r  = exp_r + 5'd1;
      mant_r = '0;
    end
    pack_word = {1'b0, exp_r, mant_r[MANT_W-1:0]};
    if (zero) pack_word = '0;
`ifdef BCD_CHECK_EN
    if (err_q) pack_word = FP_QNAN;
`endif
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      d1     <= '0;
      d2     <= '0;
      nshift <= '0;
      k      <= '0;
      zero   <= 1'b0;
      Fp_out <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          d1    <= Digit_1;
          d2    <= Digit_2;
          Busy  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: begin
          k    <= '0;
          zero <= 1'b0;
`ifdef BCD_CHECK_EN
          if (bad_digit) begin
            err_q <= 1'b1;
            state <= S_PACK;
          end else begin
`else
          begin
`endif
            nshift <= n_load;
            if (n_load == 7'd0) begin
              zero  <= 1'b1;
              state <= S_PACK;
            end else begin
              state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          nshift <= nx2[6:0];
          k      <= k + 3'd1;
          if (div_start) state <= S_DIV;
        end
        S_DIV: if (last_step) state <= S_PACK;
        S_PACK: begin
          Fp_out <= pack_word;
          Done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: if (Ack) begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
`ifdef BCD_CHECK_EN
          err_q <= 1'b0;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encode_fp.sv
// Self-checking bench for encode_fp: directed table, handshake corners,
// mid-conversion reset, and random digits against an arithmetic model.
module tb_encode_fp;
  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Ack = 1'b0;
  logic [3:0]  Digit_1 = '0;
  logic [3:0]  Digit_2 = '0;
  logic [15:0] Fp_out;
  logic        Done, Busy, Err;

  int n_pass = 0;
  int n_total = 0;

  encode_fp dut (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
    .Digit_1(Digit_1), .Digit_2(Digit_2),
    .Fp_out(Fp_out), .Done(Done), .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [15:0] fp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Exact value N/100 rounded to nearest even at 10 fraction bits
  function automatic logic [15:0] model(input int a, input int b, output int lat);
    int n, k, e;
    longint num, q, r;
`ifndef BCD_CHECK_EN
    if (a > 9) a = 9;
    if (b > 9) b = 9;
`endif
    n = 10 * a + b;
    if (n == 0) begin lat = 2; return 16'h0000; end
    k = 0;
    while (n * (1 << k) < 100) k++;
    num = longint'(n) << (10 + k);
    q = num / 100;
    r = num % 100;
    if (2 * r > 100 || (2 * r == 100 && q % 2 == 1)) q++;
    e = 15 - k;
    if (q >= 2048) begin q = q / 2; e++; end
    lat = 13 + k;
    return {1'b0, 5'(e), 10'(q - 1024)};
  endfunction

  // Start a conversion; optionally pulse Start again after edge `glitch`
  task automatic convert(input logic [3:0] a, input logic [3:0] b, input int glitch,
                         output logic [15:0] fp, output int lat);
    @(negedge clk);
    Digit_1 = a; Digit_2 = b; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == glitch) begin Start = 1'b1; Digit_1 = 4'd1; Digit_2 = 4'd0; end
      else Start = 1'b0;
      if (Done) begin lat = n; break; end
    end
    Start = 1'b0;
    fp = Fp_out;
  endtask

  task automatic ack_and_check(input string tag);
    Ack = 1'b1;
    @(negedge clk);
    Ack = 1'b0;
    check({tag, "_done_after_ack"}, int'(Done), 0);
    check({tag, "_busy_after_ack"}, int'(Busy), 0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] fp, exp_fp;
    int lat, exp_lat;
    logic [3:0] ra, rb;

    tbl[0] = '{4'd8, 4'd0, 16'h3A66, 14};
    tbl[1] = '{4'd1, 4'd0, 16'h2E66, 17};
    tbl[2] = '{4'd9, 4'd0, 16'h3B33, 14};
    tbl[3] = '{4'd0, 4'd1, 16'h211F, 20};
    tbl[4] = '{4'd5, 4'd0, 16'h3800, 14};
    tbl[5] = '{4'd0, 4'd0, 16'h0000, 2};

    repeat (3) @(negedge clk);
    check("rst_fp", int'(Fp_out), 0);
    check("rst_done", int'(Done), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_err", int'(Err), 0);
    Reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      convert(tbl[i].d1, tbl[i].d2, 0, fp, lat);
      check($sformatf("vec%0d_fp", i), int'(fp), int'(tbl[i].fp));
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("vec%0d_busy", i), int'(Busy), 1);
      ack_and_check($sformatf("vec%0d", i));
    end

    // Done held with stable output until Ack
    convert(4'd8, 4'd0, 0, fp, lat);
    repeat (4) @(negedge clk);
    check("hold_done", int'(Done), 1);
    check("hold_fp", int'(Fp_out), 16'h3A66);
    // Start together with Ack: Ack wins, Start not queued
    Start = 1'b1; Ack = 1'b1;
    @(negedge clk);
    Start = 1'b0; Ack = 1'b0;
    check("startack_done", int'(Done), 0);
    check("startack_busy", int'(Busy), 0);
    repeat (3) @(negedge clk);
    check("startack_not_queued", int'(Busy), 0);

    // Start pulsed mid-conversion is ignored
    convert(4'd8, 4'd0, 5, fp, lat);
    check("busy_start_fp", int'(fp), 16'h3A66);
    check("busy_start_lat", lat, 14);
    ack_and_check("busy_start");

    // Reset during DIV (edges 2..12 for k=1); Fp_out still holds 0.8
    @(negedge clk);
    Digit_1 = 4'd8; Digit_2 = 4'd0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (6) @(negedge clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(Busy), 0);
    check("midrst_done", int'(Done), 0);
    check("midrst_fp", int'(Fp_out), 0);
    @(negedge clk);
    Reset_n = 1'b1;
    convert(4'd8, 4'd0, 0, fp, lat);
    check("postrst_fp", int'(fp), 16'h3A66);
    check("postrst_lat", lat, 14);
    ack_and_check("postrst");

    // Invalid digit handling
    convert(4'hA, 4'd0, 0, fp, lat);
`ifdef BCD_CHECK_EN
    check("bad_err", int'(Err), 1);
    check("bad_fp", int'(fp), 16'h7E00);
    check("bad_lat", lat, 2);
    ack_and_check("bad");
    check("bad_err_clear", int'(Err), 0);
`else
    check("bad_err", int'(Err), 0);
    check("bad_fp", int'(fp), 16'h3B33);
    check("bad_lat", lat, 14);
    ack_and_check("bad");
`endif

    // Random valid digits against the model
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 9));
      rb = 4'($urandom_range(0, 9));
      exp_fp = model(int'(ra), int'(rb), exp_lat);
      convert(ra, rb, 0, fp, lat);
      check($sformatf("rnd%0d_fp_%0d%0d", i, ra, rb), int'(fp), int'(exp_fp));
      check($sformatf("rnd%0d_lat_%0d%0d", i, ra, rb), lat, exp_lat);
      ack_and_check($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
